// File: rtl/aes_core_arbiter.sv
// ---------------------------------------------------------------------------
// aes_core_arbiter
//   Shares one AES encryption core between two requesters (ch0, ch1).
//   Jobs are granted round-robin. The granted plaintext/key is latched and
//   driven to the core, which is held enabled until it reports done or a
//   timeout expires. The ciphertext (or all-zero on timeout) is then returned
//   with the channel id over a valid/ready response port. A mandatory idle
//   gap follows every job so the core always sees a fresh enable rise.
//
// Parameters
//   TIMEOUT_CYCLES : max cycles core_en stays high per job (1..255)
//   GAP_CYCLES     : min cycles core_en stays low between jobs (1..15)
//
// Ports
//   AES_clk, AES_rst_n        : clock (rising edge), async active-low reset
//   req{0,1}_valid/_ready     : job request handshake per channel
//   req{0,1}_data/_key        : 128-bit plaintext / key per channel
//   rsp_valid/rsp_ready       : response handshake
//   rsp_id, rsp_data          : responding channel, ciphertext
//   rsp_timeout               : job aborted by timeout (rsp_data is zero)
//   core_en, core_data_in,
//   core_key_in               : drive the AES core
//   core_data_out,
//   core_out_valid            : result from the AES core
// ---------------------------------------------------------------------------
module aes_core_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int GAP_CYCLES     = 2
) (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_data,
    input  logic [127:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_data,
    input  logic [127:0] req1_key,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_data,
    output logic         rsp_timeout,
    output logic         core_en,
    output logic [127:0] core_data_in,
    output logic [127:0] core_key_in,
    input  logic [127:0] core_data_out,
    input  logic         core_out_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] GapLast     = 8'(GAP_CYCLES - 1);

    state_e       state_q, state_d;
    logic         rr_last_q, rr_last_d;
    logic         id_q, id_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [127:0] data_q, data_d;
    logic [127:0] key_q, key_d;
    logic [127:0] rsp_data_q, rsp_data_d;
    logic         rsp_timeout_q, rsp_timeout_d;
    logic         grant0, grant1;

    // Grant decision. On a tie the channel that was not served last wins.
    // Gated by reset so no ready pulse can escape while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (AES_rst_n && (state_q == IDLE)) begin
            grant0 = req0_valid && (!req1_valid || rr_last_q);
            grant1 = req1_valid && (!req0_valid || !rr_last_q);
        end
    end

    // State register and all datapath registers.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state_q       <= IDLE;
            rr_last_q     <= 1'b1;
            id_q          <= 1'b0;
            cnt_q         <= 8'd0;
            data_q        <= 128'd0;
            key_q         <= 128'd0;
            rsp_data_q    <= 128'd0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            id_q          <= id_d;
            cnt_q         <= cnt_d;
            data_q        <= data_d;
            key_q         <= key_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Next-state and datapath update. cnt_q is shared: it counts enable
    // cycles in RUN and idle cycles in GAP, and is cleared on every entry.
    // In RUN a core result always takes priority over an expiring timeout.
    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        id_d          = id_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        key_d         = key_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        unique case (state_q)
            IDLE: begin
                if (grant0) begin
                    data_d    = req0_data;
                    key_d     = req0_key;
                    id_d      = 1'b0;
                    rr_last_d = 1'b0;
                    cnt_d     = 8'd0;
                    state_d   = RUN;
                end else if (grant1) begin
                    data_d    = req1_data;
                    key_d     = req1_key;
                    id_d      = 1'b1;
                    rr_last_d = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (core_out_valid) begin
                    rsp_data_d    = core_data_out;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (cnt_q == TimeoutLast) begin
                    rsp_data_d    = 128'd0;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    cnt_d   = 8'd0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == GapLast) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: enable and response valid follow the state directly, so
    // an asynchronous reset drops them in the same cycle.
    always_comb begin
        req0_ready   = grant0;
        req1_ready   = grant1;
        core_en      = (state_q == RUN);
        rsp_valid    = (state_q == RESP);
        rsp_id       = id_q;
        rsp_data     = rsp_data_q;
        rsp_timeout  = rsp_timeout_q;
        core_data_in = data_q;
        core_key_in  = key_q;
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aes_core_arbiter
//   Directed self-checking bench for aes_core_arbiter. A behavioural stub
//   stands in for the AES core: it answers a fixed latency after core_en
//   rises, returning the known FIPS-197 ciphertext for the reference
//   key/plaintext and data^key otherwise. It can be silenced to force a
//   timeout, and extra core_out_valid pulses can be injected on demand.
// ---------------------------------------------------------------------------
module tb_aes_core_arbiter;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] DATA_A   = 128'h0123456789abcdef0011223344556677;
    localparam logic [127:0] KEY_A    = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] DATA_B   = 128'hdeadbeefcafef00d1234567890abcdef;
    localparam logic [127:0] KEY_B    = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic         AES_clk = 1'b0;
    logic         AES_rst_n;
    logic         req0_valid, req0_ready;
    logic [127:0] req0_data, req0_key;
    logic         req1_valid, req1_ready;
    logic [127:0] req1_data, req1_key;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_timeout;
    logic [127:0] rsp_data;
    logic         core_en;
    logic [127:0] core_data_in, core_key_in, core_data_out;
    logic         core_out_valid;

    logic         stubOn = 1'b1;
    logic         stubValid = 1'b0;
    logic [127:0] stubData = 128'd0;
    int           stubCnt = 0;
    logic         spuriousValid = 1'b0;
    localparam int STUB_LATENCY = 5;

    int nChecks = 0;
    int nFails  = 0;

    aes_core_arbiter #(.TIMEOUT_CYCLES(64), .GAP_CYCLES(2)) dut (
        .AES_clk        (AES_clk),
        .AES_rst_n      (AES_rst_n),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_data      (req0_data),
        .req0_key       (req0_key),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_data      (req1_data),
        .req1_key       (req1_key),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .rsp_timeout    (rsp_timeout),
        .core_en        (core_en),
        .core_data_in   (core_data_in),
        .core_key_in    (core_key_in),
        .core_data_out  (core_data_out),
        .core_out_valid (core_out_valid)
    );

    always #5 AES_clk = ~AES_clk;

    assign core_out_valid = stubValid | spuriousValid;
    assign core_data_out  = stubData;

    // Core stub: one-cycle done pulse STUB_LATENCY cycles into each job.
    always @(posedge AES_clk) begin
        if (!core_en) begin
            stubCnt   <= 0;
            stubValid <= 1'b0;
        end else if (stubValid) begin
            stubValid <= 1'b0;
        end else if (stubOn && stubCnt == STUB_LATENCY - 1) begin
            stubValid <= 1'b1;
            stubCnt   <= 0;
            if (core_data_in == FIPS_PT && core_key_in == FIPS_KEY)
                stubData <= FIPS_CT;
            else
                stubData <= core_data_in ^ core_key_in;
        end else begin
            stubCnt <= stubCnt + 1;
        end
    end

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge AES_clk);
        #1;
    endtask

    task automatic waitRsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic waitGrant(output int gid);
        gid = -1;
        for (int i = 0; i < 300; i++) begin
            if (req0_ready && req1_ready) begin
                gid = 2;
                return;
            end
            if (req0_ready) begin
                gid = 0;
                return;
            end
            if (req1_ready) begin
                gid = 1;
                return;
            end
            tick();
        end
    endtask

    task automatic doReset();
        AES_rst_n = 1'b0;
        tick();
        tick();
        AES_rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        AES_rst_n  = 1'b0;
        tick();
        tick();
        nChecks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        nChecks++;
        if (core_en !== 1'b0 || rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_ctrl: core_en=%b rsp_valid=%b rsp_timeout=%b want 0", core_en, rsp_valid, rsp_timeout);
        end
        nChecks++;
        if (core_data_in !== 128'd0 || rsp_data !== 128'd0) begin
            nFails++;
            $display("[TB] FAIL reset_data: core_data_in=%h rsp_data=%h want 0", core_data_in, rsp_data);
        end
        AES_rst_n  = 1'b1;
        req1_valid = 1'b0;
        req0_data  = DATA_A;
        req0_key   = KEY_A;
        #1;
        nChecks++;
        if (req0_ready !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL reset_first_grant: req0_ready=%b want 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        #1;
        nChecks++;
        if (core_en !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL reset_prejob_en: core_en=%b want 1", core_en);
        end
        tick();
        req0_valid = 1'b1;
        AES_rst_n  = 1'b0;
        #1;
        nChecks++;
        if (core_en !== 1'b0 || rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_midjob: core_en=%b rsp_valid=%b ready=%b%b want 0", core_en, rsp_valid, req0_ready, req1_ready);
        end
        tick();
        AES_rst_n  = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        #1;
        nChecks++;
        if (req1_ready !== 1'b1 || core_en !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_idle_after: req1_ready=%b core_en=%b want 1/0", req1_ready, core_en);
        end
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        int n;
        rsp_ready  = 1'b0;
        req0_data  = FIPS_PT;
        req0_key   = FIPS_KEY;
        req0_valid = 1'b1;
        #1;
        nChecks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL single_grant: ready=%b%b want 01", req1_ready, req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        nChecks++;
        if (core_en !== 1'b1 || core_data_in !== FIPS_PT || core_key_in !== FIPS_KEY) begin
            nFails++;
            $display("[TB] FAIL single_launch: en=%b data=%h key=%h", core_en, core_data_in, core_key_in);
        end
        n = 0;
        while (!core_out_valid && n < 300) begin
            n++;
            tick();
        end
        nChecks++;
        if (core_out_valid !== 1'b1 || core_en !== 1'b1 || rsp_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL single_done_cycle: valid=%b en=%b rsp_valid=%b want 1/1/0", core_out_valid, core_en, rsp_valid);
        end
        tick();
        ok = 1'b0;
        if (rsp_valid) ok = 1'b1;
        nChecks++;
        if (!ok) begin
            nFails++;
            $display("[TB] FAIL single_latency: rsp_valid=%b want 1 one cycle after done", rsp_valid);
        end
        nChecks++;
        if (rsp_id !== 1'b0 || rsp_data !== FIPS_CT || rsp_timeout !== 1'b0 || core_en !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL single_rsp: id=%b data=%h to=%b en=%b want 0/%h/0/0", rsp_id, rsp_data, rsp_timeout, core_en, FIPS_CT);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        nChecks++;
        if (rsp_valid !== 1'b0 || core_data_in !== FIPS_PT || core_key_in !== FIPS_KEY) begin
            nFails++;
            $display("[TB] FAIL single_after: rsp_valid=%b data=%h key=%h", rsp_valid, core_data_in, core_key_in);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_contention();
        int  gid;
        bit  ok;
        logic [127:0] expData;
        doReset();
        rsp_ready  = 1'b1;
        req0_data  = DATA_A;
        req0_key   = KEY_A;
        req1_data  = DATA_B;
        req1_key   = KEY_B;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            waitGrant(gid);
            nChecks++;
            if (gid != (j % 2)) begin
                nFails++;
                $display("[TB] FAIL contention_grant%0d: got %0d want %0d", j, gid, j % 2);
            end
            expData = (j % 2 == 0) ? (DATA_A ^ KEY_A) : (DATA_B ^ KEY_B);
            tick();
            waitRsp(ok);
            nChecks++;
            if (!ok || rsp_id !== 1'((j % 2)) || rsp_data !== expData) begin
                nFails++;
                $display("[TB] FAIL contention_rsp%0d: valid=%b id=%b data=%h want id %0d data %h", j, rsp_valid, rsp_id, rsp_data, j % 2, expData);
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bad;
        rsp_ready  = 1'b0;
        req0_data  = DATA_A;
        req0_key   = KEY_A;
        req0_valid = 1'b1;
        #1;
        nChecks++;
        if (req0_ready !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL bp_grant: req0_ready=%b want 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        waitRsp(ok);
        nChecks++;
        if (!ok) begin
            nFails++;
            $display("[TB] FAIL bp_wait: rsp_valid=%b want 1", rsp_valid);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            nChecks++;
            if (rsp_valid !== 1'b1 || rsp_data !== (DATA_A ^ KEY_A) || rsp_id !== 1'b0 ||
                core_en !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL bp_hold%0d: valid=%b id=%b data=%h en=%b ready=%b%b", i, rsp_valid, rsp_id, rsp_data, core_en, req1_ready, req0_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready  = 1'b0;
        req1_valid = 1'b0;
        nChecks++;
        if (rsp_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL bp_release: rsp_valid=%b want 0", rsp_valid);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int n;
        stubOn     = 1'b0;
        rsp_ready  = 1'b0;
        req1_data  = DATA_B;
        req1_key   = KEY_B;
        req1_valid = 1'b1;
        #1;
        nChecks++;
        if (req1_ready !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL timeout_grant: req1_ready=%b want 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        n = 0;
        while (core_en && n < 300) begin
            n++;
            tick();
        end
        nChecks++;
        if (n != 64) begin
            nFails++;
            $display("[TB] FAIL timeout_en_cycles: got %0d want 64", n);
        end
        nChecks++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_data !== 128'd0 || rsp_id !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL timeout_rsp: valid=%b to=%b data=%h id=%b want 1/1/0/1", rsp_valid, rsp_timeout, rsp_data, rsp_id);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        stubOn    = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_spurious();
        bit ok;
        spuriousValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            nChecks++;
            if (rsp_valid !== 1'b0 || core_en !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL spurious_idle%0d: rsp_valid=%b core_en=%b want 0", i, rsp_valid, core_en);
            end
        end
        spuriousValid = 1'b0;
        rsp_ready  = 1'b0;
        req0_data  = DATA_B;
        req0_key   = KEY_A;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        waitRsp(ok);
        nChecks++;
        if (!ok || rsp_data !== (DATA_B ^ KEY_A)) begin
            nFails++;
            $display("[TB] FAIL spurious_job: valid=%b data=%h want %h", rsp_valid, rsp_data, DATA_B ^ KEY_A);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready     = 1'b0;
        req0_valid    = 1'b1;
        spuriousValid = 1'b1;
        #1;
        nChecks++;
        if (req0_ready !== 1'b0 || core_en !== 1'b0 || rsp_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL gap_cycle1: ready=%b en=%b rsp_valid=%b want 0", req0_ready, core_en, rsp_valid);
        end
        tick();
        nChecks++;
        if (req0_ready !== 1'b0 || core_en !== 1'b0 || rsp_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL gap_cycle2: ready=%b en=%b rsp_valid=%b want 0", req0_ready, core_en, rsp_valid);
        end
        spuriousValid = 1'b0;
        tick();
        nChecks++;
        if (req0_ready !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL gap_end_grant: req0_ready=%b want 1", req0_ready);
        end
        req0_valid = 1'b0;
        tick();
    endtask

    // Scenario sequence; each task does its own stimulus and comparisons.
    initial begin
        AES_rst_n  = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 128'd0;
        req0_key   = 128'd0;
        req1_data  = 128'd0;
        req1_key   = 128'd0;
        rsp_ready  = 1'b0;
        #2;
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_spurious();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
